// File: rtl/osr_autopull.sv
// Output shift register for a PIO state machine: pops TX FIFO words on PULL
// or autopull, shifts 1..32 bits per OUT, and stalls while data is missing.
module osr_autopull #(
   parameter bit RESET_EMPTY = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fifo_dout,
   input  logic        fifo_empty,
   output logic        fifo_pull,
   input  logic [31:0] x_in,
   input  logic        shift_right,
   input  logic        auto_pull,
   input  logic [4:0]  pull_thresh,
   input  logic        pull_req,
   input  logic        pull_block,
   input  logic        out_req,
   input  logic [4:0]  out_count,
   output logic [31:0] out_data,
   output logic        out_valid,
   output logic        stall,
   output logic [5:0]  osr_count
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] FULL_CNT = CW'(DW);

   logic [DW-1:0] osr_q, osr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] out_data_d;
   logic          out_valid_d;
   logic [DW-1:0] src;
   logic [CW-1:0] n, thr;
   logic [CW:0]   sum;
   logic          refill;

   // Decode 5-bit fields where 0 stands for a full 32-bit quantity
   always_comb begin
      n   = (out_count   == 5'd0) ? FULL_CNT : CW'(out_count);
      thr = (pull_thresh == 5'd0) ? FULL_CNT : CW'(pull_thresh);
   end

   // Request arbitration, FIFO pop, stall and next shift-register state
   always_comb begin
      osr_d       = osr_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data;
      out_valid_d = 1'b0;
      fifo_pull   = 1'b0;
      stall       = 1'b0;
      src         = osr_q;
      sum         = '0;
      refill      = 1'b0;

      if (!reset) begin
         if (pull_req) begin
            // PULL wins; a concurrent OUT waits for the next cycle
            if (out_req) begin
               stall = 1'b1;
            end
            if (auto_pull && (cnt_q < thr)) begin
               // OSR still holds enough data; PULL is a no-op
            end else if (!fifo_empty) begin
               fifo_pull = 1'b1;
               osr_d     = fifo_dout;
               cnt_d     = '0;
            end else if (pull_block) begin
               stall = 1'b1;
            end else begin
               osr_d = x_in;
               cnt_d = '0;
            end
         end else if (out_req) begin
            refill = auto_pull && (cnt_q >= thr);
            if (refill && fifo_empty) begin
               stall = 1'b1;
            end else begin
               if (refill) begin
                  // Shift straight out of the fresh FIFO word
                  fifo_pull = 1'b1;
                  src       = fifo_dout;
                  cnt_d     = n;
               end else begin
                  sum   = (CW+1)'(cnt_q) + (CW+1)'(n);
                  cnt_d = (sum > (CW+1)'(DW)) ? FULL_CNT : CW'(sum);
               end
               if (shift_right) begin
                  out_data_d = src & ~({DW{1'b1}} << n);
                  osr_d      = src >> n;
               end else begin
                  out_data_d = src >> (FULL_CNT - n);
                  osr_d      = src << n;
               end
               out_valid_d = 1'b1;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         osr_q     <= '0;
         cnt_q     <= RESET_EMPTY ? FULL_CNT : '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         osr_q     <= osr_d;
         cnt_q     <= cnt_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
      end
   end

   assign osr_count = cnt_q;

endmodule

// File: tb/tb_osr_autopull.sv
// Directed bench for osr_autopull with a 4-deep TX FIFO model on the read side.
module tb_osr_autopull;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_pull;
   logic [31:0] x_in;
   logic        shift_right;
   logic        auto_pull;
   logic [4:0]  pull_thresh;
   logic        pull_req;
   logic        pull_block;
   logic        out_req;
   logic [4:0]  out_count;
   logic [31:0] out_data;
   logic        out_valid;
   logic        stall;
   logic [5:0]  osr_count;

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO model
   logic [31:0] mem [4];
   int          rd = 0, wr = 0, fcnt = 0, pops = 0;
   logic        push_req = 1'b0;
   logic [31:0] push_data = '0;

   always #5 clk = ~clk;

   osr_autopull #(.RESET_EMPTY(1'b1)) dut (
      .clk(clk), .reset(reset),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
      .x_in(x_in), .shift_right(shift_right), .auto_pull(auto_pull),
      .pull_thresh(pull_thresh), .pull_req(pull_req), .pull_block(pull_block),
      .out_req(out_req), .out_count(out_count),
      .out_data(out_data), .out_valid(out_valid), .stall(stall), .osr_count(osr_count)
   );

   assign fifo_empty = (fcnt == 0);
   assign fifo_dout  = mem[rd];

   // FIFO pop on fifo_pull, push from the stimulus
   always @(posedge clk) begin
      int pop, psh;
      pop = (fifo_pull && fcnt > 0) ? 1 : 0;
      psh = (push_req && fcnt < 4) ? 1 : 0;
      if (pop == 1) begin
         rd   <= (rd + 1) % 4;
         pops <= pops + 1;
      end
      if (psh == 1) begin
         mem[wr] <= push_data;
         wr      <= (wr + 1) % 4;
      end
      fcnt <= fcnt + psh - pop;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      push_data = w;
      push_req  = 1'b1;
      cycle();
      push_req  = 1'b0;
   endtask

   initial begin
      logic [31:0] t1_exp [4];
      int p0;
      t1_exp = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
      for (int i = 0; i < 4; i++) mem[i] = '0;

      reset = 1'b1; x_in = '0; shift_right = 1'b0; auto_pull = 1'b0;
      pull_thresh = '0; pull_req = 1'b0; pull_block = 1'b0;
      out_req = 1'b0; out_count = '0;
      @(negedge clk);
      cycle();
      cycle();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_osr_count", 32'(osr_count), 32'd32);
      chk("rst_stall",     32'(stall), 32'd0);
      chk("rst_fifo_pull", 32'(fifo_pull), 32'd0);
      reset = 1'b0;

      // Explicit PULL, four right-shifting byte OUTs
      push_word(32'hDEADBEEF);
      p0 = pops;
      pull_req = 1'b1; pull_block = 1'b1; shift_right = 1'b1;
      #1;
      chk("t1_pull_pop",   32'(fifo_pull), 32'd1);
      chk("t1_pull_stall", 32'(stall), 32'd0);
      cycle();
      pull_req = 1'b0;
      chk("t1_cnt_after_pull", 32'(osr_count), 32'd0);
      for (int i = 0; i < 4; i++) begin
         out_req = 1'b1; out_count = 5'd8;
         #1;
         chk("t1_out_stall", 32'(stall), 32'd0);
         chk("t1_out_nopop", 32'(fifo_pull), 32'd0);
         cycle();
         chk("t1_valid", 32'(out_valid), 32'd1);
         chk("t1_data",  out_data, t1_exp[i]);
         chk("t1_cnt",   32'(osr_count), 32'(8 * (i + 1)));
      end
      out_req = 1'b0;
      cycle();
      chk("t1_valid_drop", 32'(out_valid), 32'd0);
      chk("t1_pop_total",  32'(pops - p0), 32'd1);

      // MSB-first nibbles, then one OUT past exhaustion
      push_word(32'h12345678);
      pull_req = 1'b1; shift_right = 1'b0;
      cycle();
      pull_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         out_req = 1'b1; out_count = 5'd4;
         cycle();
         chk("t2_data", out_data, (i < 8) ? 32'(i + 1) : 32'd0);
         chk("t2_cnt",  32'(osr_count), (i < 8) ? 32'(4 * (i + 1)) : 32'd32);
      end
      out_req = 1'b0;

      // Autopull with 32-bit OUTs, back to back, then a stall until a push
      auto_pull = 1'b1; pull_thresh = 5'd0; shift_right = 1'b1;
      push_word(32'hA5A5A5A5);
      push_word(32'h0F0F0F0F);
      p0 = pops;
      out_req = 1'b1; out_count = 5'd0;
      #1;
      chk("t3_pop1", 32'(fifo_pull), 32'd1);
      cycle();
      chk("t3_data1", out_data, 32'hA5A5A5A5);
      #1;
      chk("t3_pop2", 32'(fifo_pull), 32'd1);
      chk("t3_stall2", 32'(stall), 32'd0);
      cycle();
      chk("t3_data2", out_data, 32'h0F0F0F0F);
      chk("t3_valid2", 32'(out_valid), 32'd1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_stall_empty", 32'(stall), 32'd1);
         chk("t3_nopop_empty", 32'(fifo_pull), 32'd0);
         cycle();
         chk("t3_novalid", 32'(out_valid), 32'd0);
      end
      push_data = 32'h11111111; push_req = 1'b1;
      #1;
      chk("t3_stall_pushcyc", 32'(stall), 32'd1);
      cycle();
      push_req = 1'b0;
      #1;
      chk("t3_stall_exit", 32'(stall), 32'd0);
      chk("t3_pop3", 32'(fifo_pull), 32'd1);
      cycle();
      out_req = 1'b0;
      chk("t3_valid3", 32'(out_valid), 32'd1);
      chk("t3_data3",  out_data, 32'h11111111);
      chk("t3_pops",   32'(pops - p0), 32'd3);
      chk("t3_cnt",    32'(osr_count), 32'd32);
      auto_pull = 1'b0;

      // Non-blocking PULL on empty FIFO loads X
      x_in = 32'h00000055; pull_block = 1'b0; pull_req = 1'b1;
      #1;
      chk("t4_nopop",  32'(fifo_pull), 32'd0);
      chk("t4_nostall", 32'(stall), 32'd0);
      cycle();
      pull_req = 1'b0;
      chk("t4_cnt0", 32'(osr_count), 32'd0);
      out_req = 1'b1; out_count = 5'd8; shift_right = 1'b1;
      cycle();
      out_req = 1'b0;
      chk("t4_data", out_data, 32'h55);
      chk("t4_cnt8", 32'(osr_count), 32'd8);

      // PULL is a no-op while below the autopull threshold
      push_word(32'h00000077);
      auto_pull = 1'b1; pull_thresh = 5'd16; pull_req = 1'b1;
      #1;
      chk("t4b_nopop",   32'(fifo_pull), 32'd0);
      chk("t4b_nostall", 32'(stall), 32'd0);
      cycle();
      chk("t4b_cnt", 32'(osr_count), 32'd8);
      chk("t4b_fifo", 32'(fcnt), 32'd1);
      // Simultaneous PULL and OUT: PULL proceeds, OUT stalls
      auto_pull = 1'b0; pull_thresh = 5'd0;
      out_req = 1'b1; out_count = 5'd8;
      #1;
      chk("t4c_stall", 32'(stall), 32'd1);
      chk("t4c_pop",   32'(fifo_pull), 32'd1);
      cycle();
      chk("t4c_novalid", 32'(out_valid), 32'd0);
      chk("t4c_cnt",     32'(osr_count), 32'd0);
      pull_req = 1'b0;
      cycle();
      out_req = 1'b0;
      chk("t4c_data", out_data, 32'h77);
      chk("t4c_cnt8", 32'(osr_count), 32'd8);

      // Blocking PULL on empty FIFO, released by a push
      pull_block = 1'b1; pull_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t5_stall", 32'(stall), 32'd1);
         chk("t5_nopop", 32'(fifo_pull), 32'd0);
         cycle();
      end
      chk("t5_cnt_hold", 32'(osr_count), 32'd8);
      push_word(32'hCAFEF00D);
      #1;
      chk("t5_stall_exit", 32'(stall), 32'd0);
      chk("t5_pop", 32'(fifo_pull), 32'd1);
      cycle();
      pull_req = 1'b0;
      chk("t5_cnt0", 32'(osr_count), 32'd0);
      out_req = 1'b1; out_count = 5'd16; shift_right = 1'b1;
      cycle();
      out_req = 1'b0;
      chk("t5_data", out_data, 32'h0000F00D);
      chk("t5_cnt16", 32'(osr_count), 32'd16);

      // Reset during a blocking-PULL stall
      pull_req = 1'b1;
      #1;
      chk("t6_stall_pre", 32'(stall), 32'd1);
      reset = 1'b1;
      push_data = 32'hBEEF0001; push_req = 1'b1;
      #1;
      chk("t6_stall_rst", 32'(stall), 32'd0);
      chk("t6_nopop_rst", 32'(fifo_pull), 32'd0);
      cycle();
      push_req = 1'b0;
      #1;
      chk("t6_stall_after",  32'(stall), 32'd0);
      chk("t6_nopop_after",  32'(fifo_pull), 32'd0);
      chk("t6_valid_after",  32'(out_valid), 32'd0);
      chk("t6_cnt_after",    32'(osr_count), 32'd32);
      chk("t6_fifo_kept",    32'(fcnt), 32'd1);
      reset = 1'b0; pull_req = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
